envelope_gate: RTL and testbench

Hysteretic gate detector that consumes the smoothed signed stream produced by the rolling-average stage and decides when a signal is "present". It converts each qualified sample to a magnitude and compares it against runtime on/off thresholds. A four-state FSM applies an attack-qualification count and a release-hold count. The block emits a level gate, one-cycle rise/fall pulses and an optional peak-hold magnitude for the control logic downstream.

---
 rtl/envelope_gate.sv | 201 ++++++++++++++++++++
 tb/tb_envelope_gate.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/envelope_gate.sv
// Hysteretic gate detector: magnitude vs on/off thresholds with attack and release-hold counts.
// Optional peak-hold magnitude output enabled by macro ENVELOPE_GATE_PEAK_HOLD_EN.
module envelope_gate #(
    parameter int W              = 16,
    parameter int ATTACK_SAMPLES = 4,
    parameter int HOLD_SAMPLES   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] inp,
    input  logic                inp_valid,
    input  logic        [W-1:0] on_thresh,
    input  logic        [W-1:0] off_thresh,
    output logic                gate,
    output logic                gate_rise,
    output logic                gate_fall,
    output logic        [W-1:0] peak
);

    localparam int MAX_CNT = (ATTACK_SAMPLES > HOLD_SAMPLES) ? ATTACK_SAMPLES : HOLD_SAMPLES;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [1:0] ST_CLOSED    = 2'd0;
    localparam logic [1:0] ST_ARMING    = 2'd1;
    localparam logic [1:0] ST_OPEN      = 2'd2;
    localparam logic [1:0] ST_RELEASING = 2'd3;

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ATTACK = CW'(ATTACK_SAMPLES);
    localparam logic [CW-1:0] CNT_HOLD   = CW'(HOLD_SAMPLES);

    // |x| formed in W+1 bits so that the most negative input does not wrap
    function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
        logic [W:0] ext;
        logic [W:0] m;
        ext = {x[W-1], x};
        if (x[W-1]) begin
            m = ~ext + {{W{1'b0}}, 1'b1};
        end else begin
            m = ext;
        end
        if (m[W]) begin
            abs_sat = {W{1'b1}};
        end else begin
            abs_sat = m[W-1:0];
        end
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [CW-1:0] cnt_inc_s;
    logic [W-1:0]  mag_s;
    logic [W-1:0]  offe_s;
    logic          hi_s;
    logic          lo_s;
    logic          rise_s;
    logic          fall_s;
    logic          gate_r;
    logic          rise_r;
    logic          fall_r;

    // Sample classification; a misprogrammed off > on collapses to zero hysteresis
    always_comb begin
        mag_s  = abs_sat(inp);
        offe_s = (off_thresh < on_thresh) ? off_thresh : on_thresh;
        hi_s   = (mag_s >= on_thresh);
        lo_s   = (mag_s < offe_s);
    end

    // Next-state and shared attack/hold counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cnt_inc_s   = cnt_r + CNT_ONE;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        if (inp_valid) begin
            case (state_r)
                ST_CLOSED: begin
                    if (hi_s) begin
                        cnt_nxt_s = CNT_ONE;
                        if (ATTACK_SAMPLES == 32'sd1) begin
                            state_nxt_s = ST_OPEN;
                            rise_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_ARMING;
                        end
                    end else begin
                        state_nxt_s = ST_CLOSED;
                    end
                end
                ST_ARMING: begin
                    if (hi_s) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_ATTACK) begin
                            state_nxt_s = ST_OPEN;
                            rise_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_ARMING;
                        end
                    end else begin
                        state_nxt_s = ST_CLOSED;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                ST_OPEN: begin
                    if (lo_s) begin
                        cnt_nxt_s = CNT_ONE;
                        if (HOLD_SAMPLES == 32'sd1) begin
                            state_nxt_s = ST_CLOSED;
                            fall_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_RELEASING;
                        end
                    end else begin
                        state_nxt_s = ST_OPEN;
                    end
                end
                ST_RELEASING: begin
                    if (hi_s) begin
                        state_nxt_s = ST_OPEN;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (lo_s) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_HOLD) begin
                            state_nxt_s = ST_CLOSED;
                            fall_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_RELEASING;
                        end
                    end else begin
                        state_nxt_s = ST_RELEASING;
                    end
                end
                default: begin
                    state_nxt_s = ST_CLOSED;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // State, counter and registered gate outputs; pulses clear on any non-event cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_CLOSED;
            cnt_r   <= CNT_ZERO;
            gate_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gate_r  <= (state_nxt_s == ST_OPEN) || (state_nxt_s == ST_RELEASING);
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    assign gate      = gate_r;
    assign gate_rise = rise_r;
    assign gate_fall = fall_r;

`ifdef ENVELOPE_GATE_PEAK_HOLD_EN
    logic [W-1:0] peak_r;
    logic [W-1:0] peak_nxt_s;

    // Peak restarts at the opening sample, then tracks the max while the gate is high
    always_comb begin
        peak_nxt_s = peak_r;
        if (rise_s) begin
            peak_nxt_s = mag_s;
        end else if (inp_valid && ((state_r == ST_OPEN) || (state_r == ST_RELEASING))
                     && (mag_s > peak_r)) begin
            peak_nxt_s = mag_s;
        end else begin
            peak_nxt_s = peak_r;
        end
    end

    // Peak register
    always_ff @(posedge clk) begin
        if (!rst) begin
            peak_r <= {W{1'b0}};
        end else begin
            peak_r <= peak_nxt_s;
        end
    end

    assign peak = peak_r;
`else
    assign peak = {W{1'b0}};
`endif

endmodule

// File: tb/tb_envelope_gate.sv
// Scoreboard bench for envelope_gate (W=16, ATTACK=4, HOLD=3) with directed, hand-computed vectors.
module tb_envelope_gate;

    logic               clk;
    logic               rst;
    logic signed [15:0] inp;
    logic               inp_valid;
    logic        [15:0] on_thresh;
    logic        [15:0] off_thresh;
    logic               gate;
    logic               gate_rise;
    logic               gate_fall;
    logic        [15:0] peak;

    envelope_gate #(.W(16), .ATTACK_SAMPLES(4), .HOLD_SAMPLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .inp        (inp),
        .inp_valid  (inp_valid),
        .on_thresh  (on_thresh),
        .off_thresh (off_thresh),
        .gate       (gate),
        .gate_rise  (gate_rise),
        .gate_fall  (gate_fall),
        .peak       (peak)
    );

    typedef struct {
        int          due;
        int          idx;
        logic        g;
        logic        r;
        logic        f;
        logic [15:0] p;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pk(input logic [15:0] v);
`ifdef ENVELOPE_GATE_PEAK_HOLD_EN
        return v;
`else
        return 16'd0 & v;
`endif
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp_v);
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected one cycle later
    task automatic st(input logic r, input logic v, input logic [15:0] x,
                      input logic [15:0] on, input logic [15:0] off,
                      input logic g, input logic ri, input logic fa, input logic [15:0] p);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        inp_valid  = v;
        inp        = x;
        on_thresh  = on;
        off_thresh = off;
        e.due = cyc + 1;
        e.idx = step_no;
        e.g   = g;
        e.r   = ri;
        e.f   = fa;
        e.p   = pk(p);
        q.push_back(e);
        step_no++;
    endtask

    // Monitor: compare every queued expectation when its output cycle arrives
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("gate",      e.idx, {15'd0, gate},      {15'd0, e.g});
                chk("gate_rise", e.idx, {15'd0, gate_rise}, {15'd0, e.r});
                chk("gate_fall", e.idx, {15'd0, gate_fall}, {15'd0, e.f});
                chk("peak",      e.idx, peak,               e.p);
            end
        end
    end

    initial begin
        int waited;
        rst        = 1'b0;
        inp_valid  = 1'b0;
        inp        = 16'd0;
        on_thresh  = 16'd500;
        off_thresh = 16'd200;

        // reset hold with a valid hi sample present, then first cycle after release
        for (int i = 0; i < 3; i++) st(1'b0, 1'b1, 16'd1000, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);
        st(1'b1, 1'b0, 16'd1000, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);

        // three hi then a lo: never opens
        for (int i = 0; i < 3; i++) st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);

        // four hi: opens on the fourth
        for (int i = 0; i < 3; i++) st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);
        st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b1, 1'b1, 1'b0, 16'd600);
        st(1'b1, 1'b0, 16'd0,   16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);

        // release with a mid sample holding the count
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd300, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b0, 1'b0, 1'b1, 16'd600);
        st(1'b1, 1'b0, 16'd0,   16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd600);

        // reopen (peak takes the opening sample), retrigger, grow peak, close
        for (int i = 0; i < 3; i++) st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd700, 16'd500, 16'd200, 1'b1, 1'b1, 1'b0, 16'd700);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd700);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd700);
        st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd700);
        st(1'b1, 1'b1, 16'd800, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd800);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd800);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd800);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b0, 1'b0, 1'b1, 16'd800);

        // negative full scale qualifies against on=32768
        for (int i = 0; i < 3; i++) st(1'b1, 1'b1, 16'h8000, 16'h8000, 16'd200, 1'b0, 1'b0, 1'b0, 16'd800);
        st(1'b1, 1'b1, 16'h8000, 16'h8000, 16'd200, 1'b1, 1'b1, 1'b0, 16'h8000);
        st(1'b1, 1'b1, 16'd0, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'h8000);
        st(1'b1, 1'b1, 16'd0, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'h8000);
        st(1'b1, 1'b1, 16'd0, 16'd500, 16'd200, 1'b0, 1'b0, 1'b1, 16'h8000);

        // strobe gating: invalid cycles between four valid hi samples
        for (int i = 0; i < 3; i++) begin
            st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'h8000);
            st(1'b1, 1'b0, 16'd0,   16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'h8000);
        end
        st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b1, 1'b1, 1'b0, 16'd600);
        st(1'b1, 1'b0, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b0, 1'b0, 1'b1, 16'd600);

        // inverted thresholds: offe = 300
        for (int i = 0; i < 3; i++) st(1'b1, 1'b1, 16'd400, 16'd300, 16'd800, 1'b0, 1'b0, 1'b0, 16'd600);
        st(1'b1, 1'b1, 16'd400, 16'd300, 16'd800, 1'b1, 1'b1, 1'b0, 16'd400);
        st(1'b1, 1'b1, 16'd250, 16'd300, 16'd800, 1'b1, 1'b0, 1'b0, 16'd400);
        st(1'b1, 1'b1, 16'd400, 16'd300, 16'd800, 1'b1, 1'b0, 1'b0, 16'd400);
        st(1'b1, 1'b1, 16'd250, 16'd300, 16'd800, 1'b1, 1'b0, 1'b0, 16'd400);
        st(1'b1, 1'b1, 16'd250, 16'd300, 16'd800, 1'b1, 1'b0, 1'b0, 16'd400);
        st(1'b1, 1'b1, 16'd250, 16'd300, 16'd800, 1'b0, 1'b0, 1'b1, 16'd400);

        // reset mid-arming discards the count
        st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd400);
        st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd400);
        st(1'b0, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++) st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);
        st(1'b1, 1'b1, 16'd600, 16'd500, 16'd200, 1'b1, 1'b1, 1'b0, 16'd600);

        // reset mid-releasing: gate drops with no fall pulse
        st(1'b1, 1'b1, 16'd100, 16'd500, 16'd200, 1'b1, 1'b0, 1'b0, 16'd600);
        st(1'b0, 1'b1, 16'd100, 16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);
        st(1'b1, 1'b0, 16'd0,   16'd500, 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
